fetch_unit: RTL and testbench

// Instruction fetch stage. Owns the PC and drives a single-outstanding-request instruction memory port.

---
 rtl/fetch_unit_if.sv | 22 ++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch side is the master; it issues requests and consumes responses.
interface fetch_unit_if #(
  parameter int PCW    = 32,
  parameter int INSTRW = 16
);
  logic              imem_req;
  logic [PCW-1:0]    imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INSTRW-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and keeps one imem request outstanding.
// The registered output is backed by a 1-entry skid buffer and honours stall and redirect.
module fetch_unit #(
  parameter int               PCW      = 32,
  parameter int               INSTRW   = 16,
  parameter logic [PCW-1:0]   RESET_PC = '0,
  parameter int unsigned      PC_STEP  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PCW-1:0]    redirect_pc,
  fetch_unit_if.master      imem,
  output logic [PCW-1:0]    pc_out,
  output logic [INSTRW-1:0] instr_out,
  output logic              instr_valid
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [PCW-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PCW-1:0]    req_pc_q, req_pc_d;
  logic              out_vld_q, out_vld_d;
  logic [PCW-1:0]    out_pc_q, out_pc_d;
  logic [INSTRW-1:0] out_instr_q, out_instr_d;
  logic              skid_vld_q, skid_vld_d;
  logic [PCW-1:0]    skid_pc_q, skid_pc_d;
  logic [INSTRW-1:0] skid_instr_q, skid_instr_d;

  logic req, hs, resp, consume;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    out_vld_d    = out_vld_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;
    skid_vld_d   = skid_vld_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    // A full skid blocks new requests, so output reg + skid can never overflow.
    req     = (state_q == S_REQ) && !skid_vld_q;
    hs      = req && imem.imem_gnt;
    resp    = (state_q == S_WAIT) && imem.imem_rvalid;
    consume = out_vld_q && !stall;

    if (redirect) begin
      fetch_pc_d  = redirect_pc;
      out_vld_d   = 1'b0;
      out_pc_d    = '0;
      out_instr_d = '0;
      skid_vld_d  = 1'b0;
      case (state_q)
        S_REQ:   state_d = hs ? S_DRAIN : S_REQ;
        default: state_d = imem.imem_rvalid ? S_REQ : S_DRAIN;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (hs) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PCW'(PC_STEP);
            state_d    = S_WAIT;
          end
        end
        S_WAIT, S_DRAIN: begin
          if (imem.imem_rvalid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase

      if (consume) begin
        if (skid_vld_q) begin
          out_pc_d    = skid_pc_q;
          out_instr_d = skid_instr_q;
          skid_vld_d  = 1'b0;
        end else if (resp) begin
          out_pc_d    = req_pc_q;
          out_instr_d = imem.imem_rdata;
        end else begin
          out_vld_d   = 1'b0;
          out_pc_d    = '0;
          out_instr_d = '0;
        end
      end else if (!out_vld_q) begin
        if (resp) begin
          out_vld_d   = 1'b1;
          out_pc_d    = req_pc_q;
          out_instr_d = imem.imem_rdata;
        end
      end else if (resp) begin
        skid_vld_d   = 1'b1;
        skid_pc_d    = req_pc_q;
        skid_instr_d = imem.imem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      fetch_pc_q  <= RESET_PC;
      out_vld_q   <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      skid_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      out_vld_q   <= out_vld_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      skid_vld_q  <= skid_vld_d;
    end
  end

  // Payload registers are qualified by their valid flags and need no reset.
  always_ff @(posedge clk) begin
    req_pc_q     <= req_pc_d;
    skid_pc_q    <= skid_pc_d;
    skid_instr_q <= skid_instr_d;
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = fetch_pc_q;
  assign pc_out         = out_pc_q;
  assign instr_out      = out_instr_q;
  assign instr_valid    = out_vld_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small imem model answers every grant with 0xA000+addr,
// a scoreboard queue holds expected {pc, instr} and a negedge monitor checks each consumed output.
module tb_fetch_unit;

  localparam int PCW    = 32;
  localparam int INSTRW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic              redirect;
  logic [PCW-1:0]    redirect_pc;
  logic [PCW-1:0]    pc_out;
  logic [INSTRW-1:0] instr_out;
  logic              instr_valid;

  fetch_unit_if #(.PCW(PCW), .INSTRW(INSTRW)) imem_bus ();

  fetch_unit #(.PCW(PCW), .INSTRW(INSTRW), .RESET_PC('0), .PC_STEP(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem_bus),
    .pc_out      (pc_out),
    .instr_out   (instr_out),
    .instr_valid (instr_valid)
  );

  always #5 clk = ~clk;

  // Memory model: response arrives lat cycles after the grant.
  logic           gnt;
  int             lat;
  logic           dead_mode;
  logic           pend;
  int             cnt;
  logic [PCW-1:0] pend_addr;

  assign imem_bus.imem_gnt    = gnt;
  assign imem_bus.imem_rvalid = pend && (cnt == 0);
  assign imem_bus.imem_rdata  = dead_mode ? 16'hDEAD : 16'hA000 + pend_addr[15:0];

  always @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      cnt  <= 0;
    end else begin
      if (pend && cnt == 0) pend <= 1'b0;
      else if (pend)        cnt  <= cnt - 1;
      if (imem_bus.imem_req && gnt) begin
        pend      <= 1'b1;
        pend_addr <= imem_bus.imem_addr;
        cnt       <= lat - 1;
      end
    end
  end

  typedef struct packed {
    logic [PCW-1:0]    pc;
    logic [INSTRW-1:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: an output is consumed at the next edge when valid and not stalled.
  always @(negedge clk) begin
    if (!rst && instr_valid && !stall) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got pc 0x%0h instr 0x%0h, expected none", pc_out, instr_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_pc", pc_out, e.pc);
        check("sb_instr", 32'(instr_out), 32'(e.instr));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [PCW-1:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = 16'hA000 + pc[15:0];
    exp_q.push_back(e);
  endtask

  // Release stall until every expected entry is consumed, then stall again.
  task automatic drain_q(input string name);
    int k;
    k = 0;
    stall = 1'b0;
    while (exp_q.size() != 0 && k < 60) begin
      step();
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    stall = 1'b1;
  endtask

  task automatic wait_req(input string name);
    int k;
    k = 0;
    while (!imem_bus.imem_req && k < 20) begin
      step();
      k++;
    end
    check(name, 32'(imem_bus.imem_req), 32'd1);
  endtask

  task automatic flush(input logic [PCW-1:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    step();
    redirect    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    gnt = 1'b1; lat = 1; dead_mode = 1'b0;
    step();
    step();
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", pc_out, 32'd0);
    check("rst_instr", 32'(instr_out), 32'd0);
    check("rst_req", 32'(imem_bus.imem_req), 32'd1);
    check("rst_addr", imem_bus.imem_addr, 32'd0);

    // Sequential fetch, then stall filling the skid buffer.
    push(32'h0); push(32'h2); push(32'h4); push(32'h6);
    rst = 1'b0;
    step();
    check("t1_valid_c1", 32'(instr_valid), 32'd0);
    step();
    check("t1_valid_c2", 32'(instr_valid), 32'd1);
    check("t1_pc_c2", pc_out, 32'd0);
    check("t1_instr_c2", 32'(instr_out), 32'hA000);
    check("t1_addr_c2", imem_bus.imem_addr, 32'd2);
    step();
    step();
    check("t2_valid_pc2", 32'(instr_valid), 32'd1);
    check("t2_pc2", pc_out, 32'd2);
    check("t2_addr4", imem_bus.imem_addr, 32'd4);
    stall = 1'b1;
    step();
    step();
    check("t2_hold_pc", pc_out, 32'd2);
    check("t2_hold_instr", 32'(instr_out), 32'hA002);
    check("t2_hold_valid", 32'(instr_valid), 32'd1);
    check("t2_skid_req0", 32'(imem_bus.imem_req), 32'd0);
    step();
    check("t2_skid_req0_b", 32'(imem_bus.imem_req), 32'd0);
    stall = 1'b0;
    step();
    check("t2_pc4", pc_out, 32'd4);
    check("t2_req_resume", 32'(imem_bus.imem_req), 32'd1);
    check("t2_addr6", imem_bus.imem_addr, 32'd6);
    drain_q("t2_drain");

    // Redirect with stall=1 and skid full.
    repeat (5) step();
    check("t5_full_req0", 32'(imem_bus.imem_req), 32'd0);
    check("t5_full_pc", pc_out, 32'd8);
    check("t5_full_instr", 32'(instr_out), 32'hA008);
    flush(32'h40);
    check("t5_valid0", 32'(instr_valid), 32'd0);
    check("t5_instr0", 32'(instr_out), 32'd0);
    check("t5_pc0", pc_out, 32'd0);
    check("t5_addr", imem_bus.imem_addr, 32'h40);
    push(32'h40);
    drain_q("t5_drain");

    // Redirect in WAIT without a response: DRAIN drops the late 0xDEAD.
    lat = 3;
    flush(32'h80);
    wait_req("t3_wait_req");
    step();
    redirect = 1'b1; redirect_pc = 32'h100; dead_mode = 1'b1;
    step();
    redirect = 1'b0;
    check("t3_valid0", 32'(instr_valid), 32'd0);
    check("t3_drain_req0", 32'(imem_bus.imem_req), 32'd0);
    step();
    check("t3_rvalid_seen", 32'(imem_bus.imem_rvalid), 32'd1);
    check("t3_drain_req0_b", 32'(imem_bus.imem_req), 32'd0);
    step();
    check("t3_req", 32'(imem_bus.imem_req), 32'd1);
    check("t3_addr", imem_bus.imem_addr, 32'h100);
    check("t3_dropped", 32'(instr_valid), 32'd0);
    dead_mode = 1'b0;
    lat = 1;
    push(32'h100);
    drain_q("t3_drain");

    // Redirect in the same cycle as the response: no DRAIN.
    flush(32'h200);
    wait_req("t4_wait_req");
    step();
    check("t4_rvalid_seen", 32'(imem_bus.imem_rvalid), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    redirect = 1'b0;
    check("t4_req", 32'(imem_bus.imem_req), 32'd1);
    check("t4_addr", imem_bus.imem_addr, 32'h300);
    check("t4_valid0", 32'(instr_valid), 32'd0);
    push(32'h300);
    drain_q("t4_drain");

    // Reset asserted mid-WAIT.
    lat = 3;
    flush(32'h400);
    wait_req("t6_wait_req");
    step();
    rst = 1'b1;
    step();
    check("t6_valid0", 32'(instr_valid), 32'd0);
    check("t6_pc0", pc_out, 32'd0);
    check("t6_instr0", 32'(instr_out), 32'd0);
    check("t6_req", 32'(imem_bus.imem_req), 32'd1);
    check("t6_addr", imem_bus.imem_addr, 32'd0);
    rst = 1'b0;
    lat = 1;
    push(32'h0);
    drain_q("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
